// File: rtl/shift_window_pkg.sv
// Shared types and constants for the shift-register window controller.
// Holds the FSM encoding and the drop counter width.
package shift_window_pkg;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    HOLD
  } win_state_t;

  localparam int DROP_CNT_W = 16;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_window_ctrl_hop_counter.sv
// Up-counter with synchronous clear/load and a terminal-count flag.
// Used for the per-hop sample count and for the window fill level.
module hop_counter
  import shift_window_pkg::*;
#(
  parameter int           W  = 4,
  parameter logic [W-1:0] TC = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC);

endmodule

// File: rtl/shift_window_ctrl.sv
// Sample-window sequencer: fills, hops and freezes a shift register.
// Optional SHIFT_WINDOW_DROP_EN: never stall, drop samples while frozen.
module shift_window_ctrl
  import shift_window_pkg::*;
#(
  parameter int LENGTH    = 1024,
  parameter int WORDWIDTH = 8,
  parameter int HOP       = 1024,
  parameter int FCW       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [WORDWIDTH-1:0]         in_data,
  output logic                         in_ready,
  output logic                         sr_enable,
  output logic [WORDWIDTH-1:0]         sr_data,
  output logic                         sr_clear,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic [FCW-1:0]               frame_count,
  output logic [$clog2(LENGTH+1)-1:0]  fill_level
`ifdef SHIFT_WINDOW_DROP_EN
  ,
  output logic [DROP_CNT_W-1:0]        drop_count,
  output logic                         overrun
`endif
);

  localparam int CW  = cnt_w(LENGTH);
  localparam int FLW = $clog2(LENGTH + 1);

  if (HOP < 1 || HOP > LENGTH) begin : g_hop_chk
    $error("shift_window_ctrl: HOP must be in 1..LENGTH");
  end

  win_state_t     state_q, state_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic [CW-1:0]  cnt;
  logic           acc, shift, run_tc, fill_done;
  logic           fill_full, term, cnt_clr;

`ifdef SHIFT_WINDOW_DROP_EN
  assign in_ready = 1'b1;
`else
  assign in_ready = (state_q != HOLD);
`endif

  assign acc       = in_valid & in_ready & ~clear;
  assign shift     = acc & (state_q != HOLD);
  assign sr_enable = shift;
  assign sr_data   = in_data;
  assign sr_clear  = clear;

  assign fill_done = (cnt == CW'(LENGTH - 1));
  assign term      = (state_q == FILL) ? fill_done : run_tc;
  assign cnt_clr   = clear | (shift & term);

  hop_counter #(
    .W  (CW),
    .TC (CW'(HOP - 1))
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .inc_i    (shift),
    .cnt_o    (cnt),
    .tc_o     (run_tc)
  );

  hop_counter #(
    .W  (FLW),
    .TC (FLW'(LENGTH))
  ) u_fill (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clear),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .inc_i    (shift & ~fill_full),
    .cnt_o    (fill_level),
    .tc_o     (fill_full)
  );

  // Next state and frame release count; clear overrides everything.
  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    if (clear) begin
      state_d = FILL;
    end else begin
      unique case (state_q)
        FILL: if (shift && fill_done) state_d = HOLD;
        RUN:  if (shift && run_tc) state_d = HOLD;
        HOLD: begin
          if (frame_ready) begin
            state_d = RUN;
            fc_d    = fc_q + FCW'(1);
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State and frame count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  assign frame_valid = (state_q == HOLD);
  assign frame_count = fc_q;

`ifdef SHIFT_WINDOW_DROP_EN
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  ovr_q, ovr_d;
  logic                  drop;

  assign drop = acc & (state_q == HOLD);

  // Saturating drop count and sticky overrun flag.
  always_comb begin
    drop_d = drop_q;
    ovr_d  = ovr_q;
    if (clear) begin
      drop_d = '0;
      ovr_d  = 1'b0;
    end else if (drop) begin
      ovr_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  // Drop bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      ovr_q  <= ovr_d;
    end
  end

  assign drop_count = drop_q;
  assign overrun    = ovr_q;
`endif

endmodule

// File: tb/tb_shift_window_ctrl.sv
// Self-checking bench for shift_window_ctrl (two configurations).
// Frames are scoreboarded against a behavioural window model.
module tb_shift_window_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic clr1, v1, rdy1, en1, sclr1, fv1, fr1;
  logic [7:0] d1, sd1;
  logic [15:0] fc1;
  logic [3:0] fl1;
  logic clr2, v2, rdy2, en2, sclr2, fv2, fr2;
  logic [7:0] d2, sd2;
  logic [1:0] fc2;
  logic [2:0] fl2;
`ifdef SHIFT_WINDOW_DROP_EN
  logic [15:0] dc1, dc2;
  logic ov1, ov2;
  localparam logic HOLD_RDY = 1'b1;
`else
  localparam logic HOLD_RDY = 1'b0;
`endif

  shift_window_ctrl #(.LENGTH(8), .WORDWIDTH(8), .HOP(4), .FCW(16)) dut (
    .clk(clk), .rst(rst), .clear(clr1), .in_valid(v1), .in_data(d1),
    .in_ready(rdy1), .sr_enable(en1), .sr_data(sd1), .sr_clear(sclr1),
    .frame_valid(fv1), .frame_ready(fr1), .frame_count(fc1),
    .fill_level(fl1)
`ifdef SHIFT_WINDOW_DROP_EN
    , .drop_count(dc1), .overrun(ov1)
`endif
  );

  shift_window_ctrl #(.LENGTH(4), .WORDWIDTH(8), .HOP(1), .FCW(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clr2), .in_valid(v2), .in_data(d2),
    .in_ready(rdy2), .sr_enable(en2), .sr_data(sd2), .sr_clear(sclr2),
    .frame_valid(fv2), .frame_ready(fr2), .frame_count(fc2),
    .fill_level(fl2)
`ifdef SHIFT_WINDOW_DROP_EN
    , .drop_count(dc2), .overrun(ov2)
`endif
  );

  int tests = 0;
  int fails = 0;
  int exp1[$];
  int exp2[$];
  logic [7:0] win1[8];
  logic [7:0] win2[4];
  logic fvq1 = 1'b0;
  logic fvq2 = 1'b0;

  // Downstream shift register models, newest sample at index 0.
  always @(posedge clk) begin
    if (rst || sclr1) begin
      for (int i = 0; i < 8; i++) win1[i] <= '0;
    end else if (en1) begin
      for (int i = 7; i > 0; i--) win1[i] <= win1[i-1];
      win1[0] <= sd1;
    end
    if (rst || sclr2) begin
      for (int i = 0; i < 4; i++) win2[i] <= '0;
    end else if (en2) begin
      for (int i = 3; i > 0; i--) win2[i] <= win2[i-1];
      win2[0] <= sd2;
    end
  end

  // Scoreboard: on each new frame, pop the expected newest sample.
  always @(negedge clk) begin : mon
    int s;
    bit ok;
    if (fv1 === 1'b1 && fvq1 !== 1'b1) begin
      tests++;
      if (exp1.size() == 0) begin
        fails++;
        $display("FAIL frame1_unexpected: got frame newest=%0d, want none", win1[0]);
      end else begin
        s = exp1.pop_front();
        ok = 1;
        for (int i = 0; i < 8; i++) if (win1[i] !== 8'(s - i)) ok = 0;
        if (!ok) begin
          fails++;
          $display("FAIL frame1_window: got newest=%0d oldest=%0d, want %0d..%0d",
                   win1[0], win1[7], s, s - 7);
        end
      end
    end
    if (fv2 === 1'b1 && fvq2 !== 1'b1) begin
      tests++;
      if (exp2.size() == 0) begin
        fails++;
        $display("FAIL frame2_unexpected: got frame newest=%0d, want none", win2[0]);
      end else begin
        s = exp2.pop_front();
        ok = 1;
        for (int i = 0; i < 4; i++) if (win2[i] !== 8'(s - i)) ok = 0;
        if (!ok) begin
          fails++;
          $display("FAIL frame2_window: got newest=%0d oldest=%0d, want %0d..%0d",
                   win2[0], win2[3], s, s - 3);
        end
      end
    end
    fvq1 = fv1;
    fvq2 = fv2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; clr1 = 0; v1 = 0; d1 = 0; fr1 = 0;
    clr2 = 0; v2 = 0; d2 = 0; fr2 = 0;
    repeat (3) step();
    rst = 0;
    #1;
    tests++;
    if (fv1 !== 0 || fc1 !== 0 || fl1 !== 0) begin
      fails++;
      $display("FAIL reset_state: got fv=%b fc=%0d fl=%0d, want 0 0 0", fv1, fc1, fl1);
    end
    tests++;
    if (rdy1 !== 1 || en1 !== 0 || sclr1 !== 0) begin
      fails++;
      $display("FAIL reset_hs: got rdy=%b en=%b sclr=%b, want 1 0 0", rdy1, en1, sclr1);
    end
    tests++;
    if (fv2 !== 0 || fc2 !== 0 || fl2 !== 0) begin
      fails++;
      $display("FAIL reset_dut2: got fv=%b fc=%0d fl=%0d, want 0 0 0", fv2, fc2, fl2);
    end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 8; k++) begin
      v1 = 1; d1 = 8'(k);
      if (k == 8) exp1.push_back(8);
      #1;
      tests++;
      if (en1 !== 1 || fv1 !== 0) begin
        fails++;
        $display("FAIL fill_shift%0d: got en=%b fv=%b, want 1 0", k, en1, fv1);
      end
      step();
    end
    v1 = 0;
    #1;
    tests++;
    if (fv1 !== 1 || fl1 !== 8 || rdy1 !== HOLD_RDY) begin
      fails++;
      $display("FAIL fill_done: got fv=%b fl=%0d rdy=%b, want 1 8 %b",
               fv1, fl1, rdy1, HOLD_RDY);
    end
  endtask

  task automatic test_hop();
    fr1 = 1;
    step();
    fr1 = 0;
    #1;
    tests++;
    if (fc1 !== 1 || fv1 !== 0 || rdy1 !== 1) begin
      fails++;
      $display("FAIL hop_release: got fc=%0d fv=%b rdy=%b, want 1 0 1", fc1, fv1, rdy1);
    end
    for (int k = 9; k <= 12; k++) begin
      v1 = 1; d1 = 8'(k);
      if (k == 12) exp1.push_back(12);
      #1;
      tests++;
      if (en1 !== 1 || fv1 !== 0) begin
        fails++;
        $display("FAIL hop_shift%0d: got en=%b fv=%b, want 1 0", k, en1, fv1);
      end
      step();
    end
    v1 = 0;
    #1;
    tests++;
    if (fv1 !== 1 || fl1 !== 8) begin
      fails++;
      $display("FAIL hop_frame: got fv=%b fl=%0d, want 1 8", fv1, fl1);
    end
  endtask

  task automatic test_hold_stall();
    v1 = 1; d1 = 8'd99; fr1 = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      tests++;
      if (rdy1 !== HOLD_RDY || en1 !== 0) begin
        fails++;
        $display("FAIL stall%0d: got rdy=%b en=%b, want %b 0", i, rdy1, en1, HOLD_RDY);
      end
      step();
    end
    v1 = 0;
    #1;
    tests++;
    if (fv1 !== 1 || win1[0] !== 8'd12 || win1[7] !== 8'd5) begin
      fails++;
      $display("FAIL stall_window: got fv=%b new=%0d old=%0d, want 1 12 5",
               fv1, win1[0], win1[7]);
    end
`ifdef SHIFT_WINDOW_DROP_EN
    tests++;
    if (dc1 !== 16'd20 || ov1 !== 1) begin
      fails++;
      $display("FAIL stall_drop: got dc=%0d ov=%b, want 20 1", dc1, ov1);
    end
`endif
  endtask

  task automatic test_clear();
    fr1 = 1;
    step();
    fr1 = 0;
    for (int k = 13; k <= 15; k++) begin
      v1 = 1; d1 = 8'(k);
      step();
    end
    v1 = 1; d1 = 8'd16; clr1 = 1;
    #1;
    tests++;
    if (en1 !== 0 || sclr1 !== 1) begin
      fails++;
      $display("FAIL clear_comb: got en=%b sclr=%b, want 0 1", en1, sclr1);
    end
    step();
    clr1 = 0; v1 = 0;
    #1;
    tests++;
    if (fl1 !== 0 || fc1 !== 2 || fv1 !== 0 || rdy1 !== 1) begin
      fails++;
      $display("FAIL clear_state: got fl=%0d fc=%0d fv=%b rdy=%b, want 0 2 0 1",
               fl1, fc1, fv1, rdy1);
    end
`ifdef SHIFT_WINDOW_DROP_EN
    tests++;
    if (dc1 !== 0 || ov1 !== 0) begin
      fails++;
      $display("FAIL clear_drop: got dc=%0d ov=%b, want 0 0", dc1, ov1);
    end
`endif
    for (int k = 21; k <= 28; k++) begin
      v1 = 1; d1 = 8'(k);
      if (k == 28) exp1.push_back(28);
      #1;
      tests++;
      if (fv1 !== 0) begin
        fails++;
        $display("FAIL refill%0d: got fv=%b, want 0", k, fv1);
      end
      step();
    end
    v1 = 0;
    #1;
    tests++;
    if (fv1 !== 1 || fl1 !== 8 || fc1 !== 2) begin
      fails++;
      $display("FAIL refill_frame: got fv=%b fl=%0d fc=%0d, want 1 8 2", fv1, fl1, fc1);
    end
  endtask

  task automatic test_rst_hold();
    rst = 1;
    step();
    rst = 0;
    #1;
    tests++;
    if (fv1 !== 0 || fc1 !== 0 || fl1 !== 0 || rdy1 !== 1 || en1 !== 0) begin
      fails++;
      $display("FAIL rst_hold: got fv=%b fc=%0d fl=%0d rdy=%b en=%b, want 0 0 0 1 0",
               fv1, fc1, fl1, rdy1, en1);
    end
  endtask

  task automatic test_hop1_random();
    int seq = 1;
    int mfill = 0;
    int mfc = 0;
    bit mhold = 0;
    int a;
    for (int c = 0; c < 300; c++) begin
      v2 = 1'($urandom_range(0, 1));
      fr2 = ($urandom_range(0, 2) == 0);
      d2 = 8'(seq);
      #1;
      tests++;
      if (rdy2 !== (mhold ? HOLD_RDY : 1'b1) || fv2 !== mhold || fc2 !== 2'(mfc)) begin
        fails++;
        $display("FAIL hop1_c%0d: got rdy=%b fv=%b fc=%0d, want %b %b %0d",
                 c, rdy2, fv2, fc2, mhold ? HOLD_RDY : 1'b1, mhold, mfc);
      end
      if (v2 && !mhold) begin
        a = seq;
        seq++;
        if (mfill < 4) mfill++;
        if (mfill == 4) begin
          mhold = 1;
          exp2.push_back(a);
        end
      end else if (mhold && fr2) begin
        mhold = 0;
        mfc = (mfc + 1) % 4;
      end
      step();
    end
    v2 = 0; fr2 = 0;
    step();
    tests++;
    if (fl2 !== 3'd4 || fc2 !== 2'(mfc)) begin
      fails++;
      $display("FAIL hop1_end: got fl=%0d fc=%0d, want 4 %0d", fl2, fc2, mfc);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hop();
    test_hold_stall();
    test_clear();
    test_rst_hold();
    test_hop1_random();
    step();
    tests++;
    if (exp1.size() != 0 || exp2.size() != 0) begin
      fails++;
      $display("FAIL frames_pending: got %0d/%0d left, want 0/0", exp1.size(), exp2.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
